// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {IDLE, BURST, FLUSH} arb_state_t;

  // Index width for n producers, never below one bit.
  function automatic int grant_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first valid requester at or after rr_ptr, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = grant_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [IDW-1:0]     pick_id,
  output logic               pick_vld
);

  logic [IDW-1:0] cand;

  // Scan from the farthest offset down so the nearest valid wins.
  always_comb begin
    pick_id  = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        pick_id  = cand;
        pick_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among producers,
// with bounded bursts and flush sequencing.
//
// state | meaning
// IDLE  | no grant; pick next producer or start a pending flush
// BURST | granted producer streams beats until last or burst cap
// FLUSH | one-cycle wr_enable + flush pulse to the FIFO
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                              w_clk,
  input  logic                              wresetn,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic                              flush_req,
  output logic                              flush_done,
  input  logic                              fifo_full,
  output logic                              wr_enable,
  output logic                              flush,
  output logic [DATA_WIDTH-1:0]             wr_data,
  output logic [grant_idx_w(NUM_REQ)-1:0]   grant_id,
  output logic                              busy
);

  localparam int IDW  = grant_idx_w(NUM_REQ);
  localparam int CNTW = $clog2(BURST_MAX) + 1;

  arb_state_t      state, state_nxt;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  pick_id;
  logic            pick_vld;
  logic [CNTW-1:0] beat_cnt;
  logic            flush_pend;
  logic            flush_go;
  logic            g_valid;
  logic            g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic            beat;
  logic            burst_end;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .pick_id   (pick_id),
    .pick_vld  (pick_vld)
  );

  assign g_valid   = req_valid[grant_id];
  assign g_last    = req_last[grant_id];
  assign g_data    = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign beat      = (state == BURST) && g_valid && !fifo_full;
  assign burst_end = beat && (g_last || (beat_cnt == CNTW'(BURST_MAX - 1)));
  // A same-cycle flush_req in IDLE counts, so the flush lands one cycle later.
  assign flush_go  = flush_pend || flush_req;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    wr_enable  = 1'b0;
    flush      = 1'b0;
    flush_done = 1'b0;
    wr_data    = '0;
    unique case (state)
      IDLE: begin
        if (flush_go)      state_nxt = FLUSH;
        else if (pick_vld) state_nxt = BURST;
      end
      BURST: begin
        req_ready[grant_id] = !fifo_full;
        wr_enable           = beat;
        wr_data             = g_data;
        if (burst_end) state_nxt = IDLE;
      end
      FLUSH: begin
        wr_enable  = 1'b1;
        flush      = 1'b1;
        flush_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge wresetn) begin
    if (!wresetn) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_id   <= '0;
      beat_cnt   <= '0;
      flush_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == FLUSH)  flush_pend <= 1'b0;
      else if (flush_req)  flush_pend <= 1'b1;
      if (state == IDLE && !flush_go && pick_vld) begin
        grant_id <= pick_id;
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + CNTW'(1);
      end
      if (burst_end)
        rr_ptr <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: behavioural model compared every cycle, plus
// directed scenarios with hand-computed beat sequences and timings.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int BM      = 4;

  logic                    w_clk = 1'b0;
  logic                    wresetn = 1'b0;
  logic [NUM_REQ-1:0]      req_valid = '0;
  logic [NUM_REQ-1:0]      req_last = '0;
  logic [NUM_REQ*DW-1:0]   req_data = '0;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    flush_req = 1'b0;
  logic                    flush_done;
  logic                    fifo_full = 1'b0;
  logic                    wr_enable;
  logic                    flush;
  logic [DW-1:0]           wr_data;
  logic [1:0]              grant_id;
  logic                    busy;

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .w_clk(w_clk), .wresetn(wresetn), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .flush_req(flush_req),
    .flush_done(flush_done), .fifo_full(fifo_full), .wr_enable(wr_enable),
    .flush(flush), .wr_data(wr_data), .grant_id(grant_id), .busy(busy)
  );

  always #5 w_clk = ~w_clk;

  typedef struct packed {logic [7:0] d; logic l;} beat_t;
  beat_t pq [NUM_REQ][$];
  logic [NUM_REQ-1:0] acc = '0;
  logic gaps = 1'b0;
  int cyc = 0;
  int n_cmp = 0, n_bad = 0;

  // model: m_own = -1 idle, -2 flushing, else owning producer
  int m_own = -1, m_ptr = 0, m_gid = 0, m_taken = 0;
  bit m_pend = 0;

  int b_gid[$];
  int b_cyc[$];
  int b_dat[$];
  int f_cyc[$];

  int rr_g[5]   = '{0, 1, 2, 3, 0};
  int rr_d[5]   = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01};
  int bc_g[12]  = '{0, 2, 2, 2, 2, 3, 2, 2, 2, 2, 2, 2};
  int bc_d[12]  = '{8'hA0, 8'h20, 8'h21, 8'h22, 8'h23, 8'hD0, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h29};
  int bc_gap[11] = '{2, 1, 1, 1, 2, 2, 1, 1, 1, 2, 1};
  int fb_g[6]   = '{1, 1, 1, 1, 2, 0};
  int fb_d[6]   = '{8'h10, 8'h11, 8'h12, 8'h13, 8'hC0, 8'hA0};
  int fb_gap[5] = '{1, 1, 1, 4, 2};
  int fs_gap[3] = '{1, 4, 1};

  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, a, e);
    end
  endtask

  always @(posedge w_clk) cyc++;

  always @(posedge w_clk or negedge wresetn) begin
    if (!wresetn) begin
      m_own = -1; m_ptr = 0; m_gid = 0; m_taken = 0; m_pend = 0;
    end else if (m_own == -1) begin
      if (m_pend || flush_req) m_own = -2;
      else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          int c;
          c = (m_ptr + k) % NUM_REQ;
          if (m_own == -1 && req_valid[c]) begin
            m_own = c; m_gid = c; m_taken = 0;
          end
        end
      end
    end else if (m_own == -2) begin
      m_own = -1; m_pend = 0;
    end else begin
      if (flush_req) m_pend = 1;
      if (req_valid[m_own] && !fifo_full) begin
        m_taken++;
        if (req_last[m_own] || m_taken == BM) begin
          m_ptr = (m_own + 1) % NUM_REQ;
          m_own = -1;
        end
      end
    end
  end

  always @(negedge w_clk) begin
    logic [NUM_REQ-1:0] e_ready;
    logic e_we, e_fl;
    logic [DW-1:0] e_data;
    e_ready = '0; e_we = 0; e_fl = 0; e_data = '0;
    if (m_own >= 0) begin
      if (!fifo_full) e_ready[m_own] = 1'b1;
      e_we   = req_valid[m_own] & !fifo_full;
      e_data = req_data[m_own*DW +: DW];
    end else if (m_own == -2) begin
      e_we = 1'b1; e_fl = 1'b1;
    end
    cmp("req_ready", 32'(req_ready), 32'(e_ready));
    cmp("wr_enable", 32'(wr_enable), 32'(e_we));
    cmp("flush", 32'(flush), 32'(e_fl));
    cmp("flush_done", 32'(flush_done), 32'(e_fl));
    cmp("wr_data", 32'(wr_data), 32'(e_data));
    cmp("grant_id", 32'(grant_id), m_gid);
    cmp("busy", 32'(busy), 32'(m_own != -1));
    if (wr_enable && !flush) begin
      b_gid.push_back(int'(grant_id)); b_dat.push_back(int'(wr_data)); b_cyc.push_back(cyc);
    end
    if (flush && flush_done && wr_enable) f_cyc.push_back(cyc);
    acc = req_valid & req_ready;
  end

  task automatic step();
    @(posedge w_clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
    flush_req = 1'b0;
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pq[i].size() > 0) begin
        req_valid[i] = !gaps || ($urandom_range(0, 3) != 0);
        req_data[i*DW +: DW] = pq[i][0].d;
        req_last[i] = pq[i][0].l;
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*DW +: DW] = '0;
        req_last[i] = 1'b0;
      end
    end
  endtask

  task automatic push(input int i, input int d, input bit l);
    beat_t b;
    b.d = d[7:0]; b.l = l;
    pq[i].push_back(b);
  endtask

  task automatic run(input int n);
    repeat (n) begin step(); drive(); end
  endtask

  task automatic clear_logs();
    b_gid.delete(); b_dat.delete(); b_cyc.delete(); f_cyc.delete();
  endtask

  task automatic wait_beats(input int k);
    for (int t = 0; t < 60 && b_gid.size() < k; t++) begin step(); drive(); end
    cmp("wait_beats", 32'(b_gid.size() >= k), 1);
  endtask

  task automatic do_reset();
    wresetn = 1'b0; fifo_full = 1'b0; flush_req = 1'b0; gaps = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) pq[i].delete();
    drive();
    step(); step();
    wresetn = 1'b1;
    clear_logs();
    drive();
  endtask

  task automatic chk_beat(input string nm, input int k, input int eg, input int ed);
    if (k < b_gid.size()) begin
      cmp({nm, "_gid"}, b_gid[k], eg);
      cmp({nm, "_data"}, b_dat[k], ed);
    end else cmp({nm, "_missing"}, k, b_gid.size());
  endtask

  task automatic chk_gap(input string nm, input int k, input int eg);
    if (k + 1 < b_cyc.size()) cmp(nm, b_cyc[k+1] - b_cyc[k], eg);
    else cmp({nm, "_missing"}, k + 1, b_cyc.size());
  endtask

  initial begin
    int n0;
    do_reset();
    cmp("rst_busy", 32'(busy), 0);
    cmp("rst_grant", 32'(grant_id), 0);
    cmp("rst_ready", 32'(req_ready), 0);

    // round robin, last on every beat
    for (int i = 0; i < NUM_REQ; i++)
      for (int k = 0; k < 2; k++) push(i, i*16 + k, 1);
    drive();
    run(24);
    for (int k = 0; k < 5; k++) chk_beat("rr", k, rr_g[k], rr_d[k]);
    for (int k = 0; k < 4; k++) chk_gap("rr_gap", k, 2);

    // burst cap with interleaved producers
    do_reset();
    for (int k = 0; k < 10; k++) push(2, 8'h20 + k, 0);
    push(0, 8'hA0, 1);
    push(3, 8'hD0, 1);
    drive();
    run(30);
    cmp("bc_count", b_gid.size(), 12);
    for (int k = 0; k < 12; k++) chk_beat("bc", k, bc_g[k], bc_d[k]);
    for (int k = 0; k < 11; k++) chk_gap("bc_gap", k, bc_gap[k]);

    // full stall for three cycles after the second beat
    do_reset();
    for (int k = 0; k < 4; k++) push(1, 8'h10 + k, k == 3);
    drive();
    wait_beats(2);
    fifo_full = 1'b1;
    run(3);
    fifo_full = 1'b0;
    drive();
    run(10);
    cmp("fs_count", b_gid.size(), 4);
    for (int k = 0; k < 4; k++) chk_beat("fs", k, 1, 8'h10 + k);
    for (int k = 0; k < 3; k++) chk_gap("fs_gap", k, fs_gap[k]);

    // flush requested on beat 1 of a 4-beat burst
    do_reset();
    for (int k = 0; k < 4; k++) push(1, 8'h10 + k, k == 3);
    drive();
    wait_beats(1);
    flush_req = 1'b1;
    push(0, 8'hA0, 1);
    push(2, 8'hC0, 1);
    drive();
    run(20);
    for (int k = 0; k < 6; k++) chk_beat("fb", k, fb_g[k], fb_d[k]);
    for (int k = 0; k < 5; k++) chk_gap("fb_gap", k, fb_gap[k]);
    cmp("fb_flushes", f_cyc.size(), 1);
    if (f_cyc.size() > 0 && b_cyc.size() > 3) cmp("fb_flush_cyc", f_cyc[0], b_cyc[3] + 2);

    // flush and a request together in IDLE
    do_reset();
    run(2);
    flush_req = 1'b1;
    push(1, 8'h55, 1);
    drive();
    n0 = cyc;
    run(8);
    cmp("fi_flushes", f_cyc.size(), 1);
    if (f_cyc.size() > 0) cmp("fi_flush_cyc", f_cyc[0], n0 + 1);
    chk_beat("fi", 0, 1, 8'h55);
    if (b_cyc.size() > 0) cmp("fi_beat_cyc", b_cyc[0], n0 + 3);

    // reset during beat 2 of a second grant (rr_ptr was advanced to 3)
    do_reset();
    for (int k = 0; k < 8; k++) push(2, 8'h20 + k, 0);
    drive();
    wait_beats(6);
    wresetn = 1'b0;
    #1;
    cmp("mr_we", 32'(wr_enable), 0);
    cmp("mr_ready", 32'(req_ready), 0);
    cmp("mr_busy", 32'(busy), 0);
    cmp("mr_data", 32'(wr_data), 0);
    push(0, 8'h40, 1);
    push(1, 8'h50, 1);
    push(3, 8'h70, 1);
    drive();
    step(); step();
    clear_logs();
    wresetn = 1'b1;
    drive();
    run(20);
    chk_beat("mr_first", 0, 0, 8'h40);
    chk_beat("mr_second", 1, 1, 8'h50);

    // randomized traffic against the model
    do_reset();
    gaps = 1'b1;
    repeat (1500) begin
      step();
      wresetn = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 2) == 0) begin
        int p;
        p = $urandom_range(0, NUM_REQ - 1);
        if (pq[p].size() < 8) push(p, $urandom_range(0, 255), $urandom_range(0, 2) == 0);
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      flush_req = ($urandom_range(0, 24) == 0);
      drive();
    end
    wresetn = 1'b1;
    run(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
